mem_dmem_port: RTL

//  MEM-stage data-memory responder. Consumes the EX/MEM register outputs (mempr_mem_*).

---
 rtl/mem_dmem_port_pkg.sv | 45 ++++
 rtl/mem_lsu_align.sv | 41 ++++
 rtl/mem_dmem_port.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_dmem_port_pkg.sv
// Shared types and helpers for the MEM-stage data-memory port.
// Holds the write-back select code, width bit indices, FSM encoding and access-size decode.
package mem_dmem_port_pkg;

    localparam logic [1:0] WB_MEM = 2'b01;

    localparam int W_BYTE = 0;
    localparam int W_HALF = 1;
    localparam int W_WORD = 2;
    localparam int W_UNS  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // Anything that is not a clean one-hot byte/half code is handled as a word access.
    function automatic size_t decode_size(input logic [7:0] width);
        case (width[W_WORD:W_BYTE])
            3'b001:  decode_size = SZ_BYTE;
            3'b010:  decode_size = SZ_HALF;
            default: decode_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_t size, input logic [1:0] off);
        is_misaligned = ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
    endfunction

    function automatic logic [1:0] force_align(input size_t size, input logic [1:0] off);
        case (size)
            SZ_HALF: force_align = {off[1], 1'b0};
            SZ_WORD: force_align = 2'b00;
            default: force_align = off;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: store byte steering and strobes, load lane extract with
// sign or zero extension.
module mem_lsu_align
    import mem_dmem_port_pkg::*;
(
    input  size_t       size,
    input  logic [1:0]  off,
    input  logic        uns,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  lane8;
    logic [15:0] lane16;

    always_comb begin
        lane8  = ld_rdata[{off, 3'b000} +: 8];
        lane16 = ld_rdata[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: begin
                st_wdata = {4{st_data[7:0]}};
                st_wstrb = 4'b0001 << off;
                ld_data  = {{24{~uns & lane8[7]}}, lane8};
            end
            SZ_HALF: begin
                st_wdata = {2{st_data[15:0]}};
                st_wstrb = 4'b0011 << off;
                ld_data  = {{16{~uns & lane16[15]}}, lane16};
            end
            default: begin
                st_wdata = st_data;
                st_wstrb = 4'b1111;
                ld_data  = ld_rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_dmem_port.sv
// MEM-stage data-memory responder: one req/ack bus transaction per load or store, stalling until ack.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses on misalign_err instead of forcing alignment.
module mem_dmem_port
    import mem_dmem_port_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        mempr_mem_is_write_dmem,
    input  logic [1:0]  mempr_mem_wb_select,
    input  logic [7:0]  mempr_mem_write_width,
    input  logic [31:0] mempr_mem_dmem_write_data,
    input  logic [31:0] mempr_mem_alu_res,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_wstrb,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        mem_stall,
    output logic [31:0] mem_load_data,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        misalign_err,
`endif
    output logic        mem_load_valid
);

    state_t      state_q, state_d;
    size_t       size_q, size_d;
    logic        we_q, we_d;
    logic [1:0]  off_q, off_d;
    logic        uns_q, uns_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        ld_valid_q, ld_valid_d;
    logic        misalign_q, misalign_d;

    logic        access;
    size_t       in_size;
    logic [1:0]  in_off;
    logic        in_mis;
    size_t       al_size;
    logic [1:0]  al_off;
    logic [31:0] al_wdata;
    logic [3:0]  al_wstrb;
    logic [31:0] al_ld;
    logic        unused_width_hi;

    assign access  = mempr_mem_is_write_dmem | (mempr_mem_wb_select == WB_MEM);
    assign in_size = decode_size(mempr_mem_write_width);
    assign unused_width_hi = ^mempr_mem_write_width[7:4];

`ifdef MEM_MISALIGN_TRAP_EN
    assign in_off = mempr_mem_alu_res[1:0];
    assign in_mis = is_misaligned(in_size, mempr_mem_alu_res[1:0]);
    assign misalign_err = misalign_q;
`else
    logic unused_misalign;
    assign in_off = force_align(in_size, mempr_mem_alu_res[1:0]);
    assign in_mis = 1'b0;
    assign unused_misalign = misalign_q;
`endif

    // Stores steer from the live inputs in IDLE; loads extract with the latched size/offset in REQ.
    assign al_size = (state_q == ST_IDLE) ? in_size : size_q;
    assign al_off  = (state_q == ST_IDLE) ? in_off  : off_q;

    mem_lsu_align u_align (
        .size     (al_size),
        .off      (al_off),
        .uns      (uns_q),
        .st_data  (mempr_mem_dmem_write_data),
        .st_wdata (al_wdata),
        .st_wstrb (al_wstrb),
        .ld_rdata (dbus_rdata),
        .ld_data  (al_ld)
    );

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        we_d       = we_q;
        off_d      = off_q;
        uns_d      = uns_q;
        req_d      = req_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        ld_data_d  = ld_data_q;
        ld_valid_d = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    we_d    = mempr_mem_is_write_dmem;
                    size_d  = in_size;
                    off_d   = in_off;
                    uns_d   = mempr_mem_write_width[W_UNS];
                    addr_d  = {mempr_mem_alu_res[31:2], 2'b00};
                    wdata_d = mempr_mem_is_write_dmem ? al_wdata : 32'h0;
                    wstrb_d = mempr_mem_is_write_dmem ? al_wstrb : 4'h0;
                    if (in_mis) begin
                        misalign_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        req_d   = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (dbus_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                    if (!we_q) begin
                        ld_data_d  = al_ld;
                        ld_valid_d = 1'b1;
                    end
                end
            end
            // Inputs are deliberately not looked at here: the pipeline only advances after this cycle.
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            size_q     <= SZ_WORD;
            we_q       <= 1'b0;
            off_q      <= 2'b00;
            uns_q      <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
            ld_data_q  <= 32'h0;
            ld_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            we_q       <= we_d;
            off_q      <= off_d;
            uns_q      <= uns_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            ld_data_q  <= ld_data_d;
            ld_valid_q <= ld_valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign dbus_req       = req_q;
    assign dbus_we        = we_q;
    assign dbus_addr      = addr_q;
    assign dbus_wdata     = wdata_q;
    assign dbus_wstrb     = wstrb_q;
    assign mem_load_data  = ld_data_q;
    assign mem_load_valid = ld_valid_q;
    assign mem_stall      = ~sys_rst & (((state_q == ST_IDLE) & access) | (state_q == ST_REQ));

endmodule
